// File: rtl/esm_buffer_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// esm_pkg
// Shared definitions for the ESM instruction buffer sequencer:
//   - RV32 register-field positions inside an instruction word
//   - sequencer FSM state encoding
//   - per-entry sideband record kept alongside each buffered instruction
//   - register-conflict helper used by the writeback scoreboard
// ---------------------------------------------------------------------------
package esm_pkg;

  // RV32 field layout: rd [11:7], rs1 [19:15], rs2 [24:20]
  localparam int RD_LSB  = 7;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int REG_W   = 5;

  typedef logic [REG_W-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ISSUE = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // Decoded fields the sequencer needs to judge hazards at issue time
  typedef struct packed {
    reg_addr_t rd;
    reg_addr_t rs1;
    reg_addr_t rs2;
    logic      reg_write;
    logic      alu_src;
  } sideband_t;

  // A source conflicts with a pending writeback only when both name the
  // same register and that register is not x0 (x0 is never written).
  function automatic logic src_conflicts(input reg_addr_t src,
                                         input reg_addr_t wb_rd,
                                         input logic      wb_valid);
    return wb_valid && (src != 5'd0) && (src == wb_rd);
  endfunction

endpackage

// File: rtl/esm_buffer_sequencer_if.sv
// ---------------------------------------------------------------------------
// esm_buffer_sequencer_if
// Bundles the enqueue handshake, issue handshake, flush and buffer-index
// signals of the sequencer.
//   master : producer/consumer side (drives in_valid, Instr_in, RegWrite,
//            ALUSrc, out_ready, flush; observes everything else)
//   slave  : the sequencer itself
// ---------------------------------------------------------------------------
interface esm_buffer_sequencer_if #(
  parameter int Instruction_word_size = 32,
  parameter int bs                    = 16
);
  localparam int IDX_W = $clog2(bs);

  logic                             flush;
  logic                             in_valid;
  logic                             in_ready;
  logic [Instruction_word_size-1:0] Instr_in;
  logic                             RegWrite;
  logic                             ALUSrc;
  logic                             wr_en;
  logic [IDX_W-1:0]                 wr_index;
  logic [IDX_W-1:0]                 rd_index;
  logic                             out_valid;
  logic                             out_ready;
  logic [IDX_W:0]                   count;
  logic                             full;
  logic                             empty;
  logic                             stall;

  modport master (
    output flush, in_valid, Instr_in, RegWrite, ALUSrc, out_ready,
    input  in_ready, wr_en, wr_index, rd_index, out_valid, count,
           full, empty, stall
  );

  modport slave (
    input  flush, in_valid, Instr_in, RegWrite, ALUSrc, out_ready,
    output in_ready, wr_en, wr_index, rd_index, out_valid, count,
           full, empty, stall
  );

endinterface

// File: rtl/esm_buffer_sequencer_scoreboard.sv
// ---------------------------------------------------------------------------
// esm_scoreboard
// Fixed-latency writeback scoreboard. Each issued instruction that writes a
// non-zero rd enters stage 0 and walks through WB_LAT stages, one per cycle;
// while it is in any stage its rd counts as "in flight". The head
// instruction's sources are compared against every stage to raise hazard.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   flush             synchronous clear of all stages
//   issue_fire        head instruction issues this cycle
//   issue_reg_write   issuing instruction writes rd
//   issue_rd          issuing instruction's rd
//   head_rs1/rs2      head instruction's source registers
//   head_alu_src      head uses an immediate, so rs2 is ignored
//   hazard            head reads a register still in flight
// ---------------------------------------------------------------------------
module esm_scoreboard
  import esm_pkg::*;
#(
  parameter int WB_LAT = 3
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      flush,
  input  logic      issue_fire,
  input  logic      issue_reg_write,
  input  reg_addr_t issue_rd,
  input  reg_addr_t head_rs1,
  input  reg_addr_t head_rs2,
  input  logic      head_alu_src,
  output logic      hazard
);

  logic [WB_LAT-1:0]      valid_q, valid_d;
  reg_addr_t [WB_LAT-1:0] rd_q, rd_d;
  logic                   load_s;
  logic                   rs1_hit_s;
  logic                   rs2_hit_s;

  // Writes to x0 are architecturally discarded, so they never enter.
  assign load_s = issue_fire & issue_reg_write & (issue_rd != 5'd0);

  // Next-stage shift: stage 0 takes the new writer, older stages age by one
  always_comb begin
    valid_d = '0;
    rd_d    = '0;
    if (flush) begin
      valid_d = '0;
      rd_d    = '0;
    end else begin
      valid_d[0] = load_s;
      rd_d[0]    = load_s ? issue_rd : 5'd0;
      for (int i = 1; i < WB_LAT; i++) begin
        valid_d[i] = valid_q[i-1];
        rd_d[i]    = rd_q[i-1];
      end
    end
  end

  // Scoreboard stage registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      rd_q    <= '0;
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
    end
  end

  // Compare the head sources against every in-flight destination
  always_comb begin
    rs1_hit_s = 1'b0;
    rs2_hit_s = 1'b0;
    for (int i = 0; i < WB_LAT; i++) begin
      rs1_hit_s = rs1_hit_s | src_conflicts(head_rs1, rd_q[i], valid_q[i]);
      rs2_hit_s = rs2_hit_s | src_conflicts(head_rs2, rd_q[i], valid_q[i]);
    end
    hazard = rs1_hit_s | (~head_alu_src & rs2_hit_s);
  end

endmodule

// File: rtl/esm_buffer_sequencer.sv
// ---------------------------------------------------------------------------
// esm_buffer_sequencer
// Sequences the ESM instruction buffer: accepts decoded instructions on a
// valid/ready handshake, assigns each a circular write slot, and presents
// them in order from a circular read slot. Issue is held while the head
// reads a register that an earlier instruction has not yet written back.
// The instruction words live in the external buffer; this block keeps only
// the per-slot sideband it needs for hazard checks.
// Parameters:
//   Instruction_word_size  instruction width (RV32 field layout)
//   bs                     buffer depth, power of two, >= 2
//   WB_LAT                 issue-to-writeback latency in cycles, >= 1
// Ports:
//   clk   clock, rising edge
//   rst   asynchronous active-low reset
//   bus   esm_buffer_sequencer_if.slave:
//         flush, in_valid/in_ready/Instr_in/RegWrite/ALUSrc (enqueue),
//         wr_en/wr_index (buffer write), rd_index (head slot),
//         out_valid/out_ready (issue), count/full/empty/stall (status)
// ---------------------------------------------------------------------------
module esm_buffer_sequencer
  import esm_pkg::*;
#(
  parameter int Instruction_word_size = 32,
  parameter int bs                    = 16,
  parameter int WB_LAT                = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  esm_buffer_sequencer_if.slave bus
);

  localparam int               IDX_W    = $clog2(bs);
  localparam logic [IDX_W:0]   BS_COUNT = (IDX_W+1)'(bs);
  localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W+1)'(1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0]     rd_idx_q, rd_idx_d;
  logic [IDX_W:0]       count_q, count_d;
  sideband_t [bs-1:0]   sb_q, sb_d;

  sideband_t            new_sb_s;
  sideband_t            head_s;
  logic                 full_s;
  logic                 empty_s;
  logic                 hazard_s;
  logic                 in_ready_s;
  logic                 out_valid_s;
  logic                 stall_s;
  logic                 enq_fire_s;
  logic                 iss_fire_s;
  logic                 unused_instr_s;

  // Only the register fields are kept; the rest of the word is the
  // buffer's business.
  assign unused_instr_s = ^bus.Instr_in;
  assign new_sb_s = {bus.Instr_in[RD_LSB  +: REG_W],
                     bus.Instr_in[RS1_LSB +: REG_W],
                     bus.Instr_in[RS2_LSB +: REG_W],
                     bus.RegWrite,
                     bus.ALUSrc};
  assign head_s   = sb_q[rd_idx_q];

  assign full_s   = (count_q == BS_COUNT);
  assign empty_s  = (count_q == {(IDX_W+1){1'b0}});

  // Flush wins over both handshakes in the same cycle.
  assign enq_fire_s = bus.in_valid & in_ready_s  & ~bus.flush;
  assign iss_fire_s = out_valid_s  & bus.out_ready & ~bus.flush;

  esm_scoreboard #(
    .WB_LAT (WB_LAT)
  ) u_scoreboard (
    .clk             (clk),
    .rst             (rst),
    .flush           (bus.flush),
    .issue_fire      (iss_fire_s),
    .issue_reg_write (head_s.reg_write),
    .issue_rd        (head_s.rd),
    .head_rs1        (head_s.rs1),
    .head_rs2        (head_s.rs2),
    .head_alu_src    (head_s.alu_src),
    .hazard          (hazard_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; driven from next occupancy so a fresh entry is
  // visible as ISSUE right after the edge that stored it
  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = FLUSH;
    end else begin
      case (state_q)
        EMPTY: begin
          if (count_d != {(IDX_W+1){1'b0}}) state_d = ISSUE;
          else                              state_d = EMPTY;
        end
        ISSUE: begin
          if (count_d == {(IDX_W+1){1'b0}}) state_d = EMPTY;
          else                              state_d = ISSUE;
        end
        FLUSH:   state_d = EMPTY;
        default: state_d = EMPTY;
      endcase
    end
  end

  // FSM outputs: handshake readiness and hazard-gated issue
  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    stall_s     = 1'b0;
    case (state_q)
      EMPTY: begin
        in_ready_s = ~full_s;
      end
      ISSUE: begin
        in_ready_s  = ~full_s;
        out_valid_s = ~hazard_s;
        stall_s     = hazard_s;
      end
      FLUSH: begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        stall_s     = 1'b0;
      end
      default: begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        stall_s     = 1'b0;
      end
    endcase
  end

  // Next indices, occupancy and sideband storage
  always_comb begin
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    count_d  = count_q;
    sb_d     = sb_q;
    if (bus.flush) begin
      wr_idx_d = '0;
      rd_idx_d = '0;
      count_d  = '0;
    end else begin
      if (enq_fire_s) begin
        sb_d[wr_idx_q] = new_sb_s;
        wr_idx_d       = wr_idx_q + IDX_ONE;
      end else begin
        wr_idx_d = wr_idx_q;
      end
      if (iss_fire_s) begin
        rd_idx_d = rd_idx_q + IDX_ONE;
      end else begin
        rd_idx_d = rd_idx_q;
      end
      // Simultaneous enqueue and issue leave occupancy unchanged
      case ({enq_fire_s, iss_fire_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      count_q  <= '0;
      sb_q     <= '0;
    end else begin
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      count_q  <= count_d;
      sb_q     <= sb_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.stall     = stall_s;
  assign bus.wr_en     = enq_fire_s;
  assign bus.wr_index  = wr_idx_q;
  assign bus.rd_index  = rd_idx_q;
  assign bus.count     = count_q;
  assign bus.full      = full_s;
  assign bus.empty     = empty_s;

endmodule

// File: tb/tb_esm_buffer_sequencer.sv
// ---------------------------------------------------------------------------
// tb_esm_buffer_sequencer
// Self-checking bench for esm_buffer_sequencer. A queue-based reference
// model tracks buffered entries, issue/enqueue totals and recently issued
// writers with their issue cycle; directed scenarios and a randomized run
// compare the DUT against it and against hand-derived constants.
// ---------------------------------------------------------------------------
module tb_esm_buffer_sequencer;
  import esm_pkg::*;

  localparam int IW  = 32;
  localparam int BS  = 16;
  localparam int WBL = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  esm_buffer_sequencer_if #(.Instruction_word_size(IW), .bs(BS)) bus ();

  esm_buffer_sequencer #(
    .Instruction_word_size (IW),
    .bs                    (BS),
    .WB_LAT                (WBL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- reference model ----------------
  typedef struct { int rd; int rs1; int rs2; bit rw; bit alu; } ent_t;
  typedef struct { int rd; int when; } wb_t;

  ent_t mq[$];
  wb_t  wbq[$];
  int   m_wr, m_rd, m_cyc;
  bit   m_flushing;

  int   n_cmp = 0;
  int   n_bad = 0;

  bit   e_in_ready, e_out_valid, e_stall, e_wr_en, e_full, e_empty;
  int   e_count, e_wr_idx, e_rd_idx;

  function automatic bit in_flight(int r);
    if (r == 0) return 1'b0;
    foreach (wbq[i])
      if (wbq[i].rd == r && (m_cyc - wbq[i].when) < WBL) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    mq.delete();
    wbq.delete();
    m_wr = 0; m_rd = 0; m_cyc = 0; m_flushing = 1'b0;
  endtask

  task automatic model_expect();
    bit haz;
    haz = 1'b0;
    if (mq.size() > 0)
      haz = in_flight(mq[0].rs1) || (!mq[0].alu && in_flight(mq[0].rs2));
    e_count     = mq.size();
    e_full      = (e_count == BS);
    e_empty     = (e_count == 0);
    e_in_ready  = !e_full && !m_flushing;
    e_out_valid = (e_count > 0) && !m_flushing && !haz;
    e_stall     = (e_count > 0) && !m_flushing && haz;
    e_wr_en     = bus.in_valid && e_in_ready && !bus.flush;
    e_wr_idx    = m_wr % BS;
    e_rd_idx    = m_rd % BS;
  endtask

  // One rising edge; the model advances with the inputs held across it
  task automatic tick();
    bit enq, iss, fl;
    ent_t e;
    model_expect();
    fl    = bus.flush;
    enq   = e_wr_en;
    iss   = e_out_valid && bus.out_ready && !fl;
    e.rd  = int'(bus.Instr_in[11:7]);
    e.rs1 = int'(bus.Instr_in[19:15]);
    e.rs2 = int'(bus.Instr_in[24:20]);
    e.rw  = bus.RegWrite;
    e.alu = bus.ALUSrc;
    @(posedge clk);
    m_cyc++;
    if (fl) begin
      mq.delete(); wbq.delete(); m_wr = 0; m_rd = 0; m_flushing = 1'b1;
    end else begin
      m_flushing = 1'b0;
      if (iss) begin
        if (mq[0].rw && mq[0].rd != 0) wbq.push_back('{rd: mq[0].rd, when: m_cyc});
        void'(mq.pop_front());
        m_rd++;
      end
      if (enq) begin
        mq.push_back(e);
        m_wr++;
      end
    end
    #1;
  endtask

  task automatic set_in(input bit v, input logic [31:0] ins, input bit rw,
                        input bit alu, input bit ordy, input bit fl);
    bus.in_valid  = v;
    bus.Instr_in  = ins;
    bus.RegWrite  = rw;
    bus.ALUSrc    = alu;
    bus.out_ready = ordy;
    bus.flush     = fl;
    #1;
  endtask

  function automatic logic [31:0] r_type(int rd, int rs1, int rs2);
    return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), 7'b0110011};
  endfunction

  function automatic logic [31:0] i_type(int rd, int rs1, int imm);
    return {12'(imm), 5'(rs1), 3'd0, 5'(rd), 7'b0010011};
  endfunction

  task automatic do_flush();
    set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    n_cmp++; if ({bus.wr_index, bus.rd_index, bus.count} !== 13'd0) begin n_bad++; $display("FAIL reset_idx_count: got %h want 0", {bus.wr_index, bus.rd_index, bus.count}); end
    n_cmp++; if ({bus.empty, bus.full, bus.in_ready} !== 3'b101) begin n_bad++; $display("FAIL reset_flags: empty/full/in_ready got %b want 101", {bus.empty, bus.full, bus.in_ready}); end
    n_cmp++; if ({bus.out_valid, bus.stall, bus.wr_en} !== 3'b000) begin n_bad++; $display("FAIL reset_issue: out_valid/stall/wr_en got %b want 000", {bus.out_valid, bus.stall, bus.wr_en}); end
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < BS; i++) begin
      set_in(1'b1, i_type(i + 1, 0, i), 1'b1, 1'b1, 1'b0, 1'b0);
      n_cmp++; if (bus.wr_en !== 1'b1 || bus.wr_index !== 4'(i)) begin n_bad++; $display("FAIL fill_write: wr_en=%b wr_index=%0d want 1/%0d", bus.wr_en, bus.wr_index, i); end
      tick();
    end
    set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if ({bus.full, bus.in_ready} !== 2'b10 || bus.count !== 5'd16) begin n_bad++; $display("FAIL fill_full: full=%b in_ready=%b count=%0d want 1/0/16", bus.full, bus.in_ready, bus.count); end
    n_cmp++; if (bus.wr_index !== 4'd0 || bus.rd_index !== 4'd0) begin n_bad++; $display("FAIL fill_idx: wr=%0d rd=%0d want 0/0", bus.wr_index, bus.rd_index); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 20; k++) begin
      set_in(1'b1, i_type(int'($urandom_range(1, 31)), 0, int'($urandom_range(0, 4095))), 1'b1, 1'b1, 1'b1, 1'b0);
      model_expect();
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.wr_en !== (k != 0)) begin n_bad++; $display("FAIL b2b_fire[%0d]: out_valid=%b wr_en=%b want 1/%b", k, bus.out_valid, bus.wr_en, k != 0); end
      n_cmp++; if (bus.count !== ((k == 0) ? 5'd16 : 5'd15)) begin n_bad++; $display("FAIL b2b_count[%0d]: got %0d want %0d", k, bus.count, (k == 0) ? 16 : 15); end
      n_cmp++; if (bus.rd_index !== 4'(k) || bus.wr_index !== 4'(e_wr_idx)) begin n_bad++; $display("FAIL b2b_idx[%0d]: rd=%0d wr=%0d want %0d/%0d", k, bus.rd_index, bus.wr_index, k % 16, e_wr_idx); end
      tick();
    end
    set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (bus.count !== 5'd15 || bus.rd_index !== 4'd4 || bus.wr_index !== 4'd3) begin n_bad++; $display("FAIL b2b_end: count=%0d rd=%0d wr=%0d want 15/4/3", bus.count, bus.rd_index, bus.wr_index); end
    do_flush();
  endtask

  task automatic test_hazard();
    do_flush();
    set_in(1'b1, r_type(5, 1, 2), 1'b1, 1'b0, 1'b0, 1'b0); tick();
    set_in(1'b1, r_type(6, 5, 3), 1'b1, 1'b0, 1'b0, 1'b0); tick();
    set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++; if ({bus.out_valid, bus.stall} !== 2'b10) begin n_bad++; $display("FAIL haz_first: out_valid/stall got %b want 10", {bus.out_valid, bus.stall}); end
    tick();
    for (int c = 1; c <= 3; c++) begin
      n_cmp++; if ({bus.out_valid, bus.stall} !== 2'b01) begin n_bad++; $display("FAIL haz_stall[t+%0d]: out_valid/stall got %b want 01", c, {bus.out_valid, bus.stall}); end
      tick();
    end
    n_cmp++; if ({bus.out_valid, bus.stall} !== 2'b10) begin n_bad++; $display("FAIL haz_release: out_valid/stall got %b want 10", {bus.out_valid, bus.stall}); end
    tick();
    n_cmp++; if (bus.empty !== 1'b1 || bus.rd_index !== 4'd2) begin n_bad++; $display("FAIL haz_done: empty=%b rd=%0d want 1/2", bus.empty, bus.rd_index); end
  endtask

  task automatic test_zero_reg();
    logic [31:0] ins_a [4];
    bit          alu_a [4];
    ins_a[0] = i_type(0, 0, 1); alu_a[0] = 1'b1;
    ins_a[1] = r_type(7, 0, 0); alu_a[1] = 1'b0;
    ins_a[2] = i_type(4, 0, 5); alu_a[2] = 1'b1;
    ins_a[3] = i_type(8, 9, 4); alu_a[3] = 1'b1;
    for (int p = 0; p < 2; p++) begin
      do_flush();
      set_in(1'b1, ins_a[2*p],   1'b1, alu_a[2*p],   1'b0, 1'b0); tick();
      set_in(1'b1, ins_a[2*p+1], 1'b1, alu_a[2*p+1], 1'b0, 1'b0); tick();
      set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int c = 0; c < 2; c++) begin
        n_cmp++; if ({bus.out_valid, bus.stall} !== 2'b10) begin n_bad++; $display("FAIL zero_nostall[%0d.%0d]: out_valid/stall got %b want 10", p, c, {bus.out_valid, bus.stall}); end
        tick();
      end
      n_cmp++; if (bus.empty !== 1'b1) begin n_bad++; $display("FAIL zero_drain[%0d]: empty=%b want 1", p, bus.empty); end
    end
  endtask

  task automatic test_flush();
    do_flush();
    set_in(1'b1, r_type(5, 1, 2), 1'b1, 1'b0, 1'b0, 1'b0); tick();
    set_in(1'b1, r_type(6, 5, 3), 1'b1, 1'b0, 1'b0, 1'b0); tick();
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, i_type(10 + i, 0, i), 1'b1, 1'b1, 1'b0, 1'b0); tick();
    end
    set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    n_cmp++; if (bus.count !== 5'd5 || bus.stall !== 1'b1) begin n_bad++; $display("FAIL flush_setup: count=%0d stall=%b want 5/1", bus.count, bus.stall); end
    set_in(1'b1, i_type(14, 0, 1), 1'b1, 1'b1, 1'b1, 1'b1);
    n_cmp++; if (bus.wr_en !== 1'b0) begin n_bad++; $display("FAIL flush_noenq: wr_en=%b want 0", bus.wr_en); end
    tick();
    set_in(1'b1, i_type(15, 0, 1), 1'b1, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (bus.count !== 5'd0 || bus.wr_index !== 4'd0 || bus.rd_index !== 4'd0) begin n_bad++; $display("FAIL flush_zero: count=%0d wr=%0d rd=%0d want 0/0/0", bus.count, bus.wr_index, bus.rd_index); end
    n_cmp++; if ({bus.empty, bus.stall, bus.in_ready, bus.out_valid, bus.wr_en} !== 5'b10000) begin n_bad++; $display("FAIL flush_state: empty/stall/in_ready/out_valid/wr_en got %b want 10000", {bus.empty, bus.stall, bus.in_ready, bus.out_valid, bus.wr_en}); end
    tick();
    set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (bus.in_ready !== 1'b1 || bus.empty !== 1'b1) begin n_bad++; $display("FAIL flush_recover: in_ready=%b empty=%b want 1/1", bus.in_ready, bus.empty); end
  endtask

  task automatic test_random();
    bit v, ordy, fl, rw, alu;
    do_flush();
    for (int n = 0; n < 400; n++) begin
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 59) == 0);
      rw   = ($urandom_range(0, 1) != 0);
      alu  = ($urandom_range(0, 1) != 0);
      set_in(v, r_type(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7))), rw, alu, ordy, fl);
      model_expect();
      n_cmp++; if (bus.count !== 5'(e_count)) begin n_bad++; $display("FAIL rnd_count[%0d]: got %0d want %0d", n, bus.count, e_count); end
      n_cmp++; if (bus.count > 5'd16) begin n_bad++; $display("FAIL rnd_count_bound[%0d]: got %0d want <= 16", n, bus.count); end
      n_cmp++; if ({bus.full, bus.empty} !== {e_full, e_empty}) begin n_bad++; $display("FAIL rnd_full_empty[%0d]: got %b want %b", n, {bus.full, bus.empty}, {e_full, e_empty}); end
      n_cmp++; if ({bus.in_ready, bus.wr_en} !== {e_in_ready, e_wr_en}) begin n_bad++; $display("FAIL rnd_enq[%0d]: in_ready/wr_en got %b want %b", n, {bus.in_ready, bus.wr_en}, {e_in_ready, e_wr_en}); end
      n_cmp++; if ({bus.out_valid, bus.stall} !== {e_out_valid, e_stall}) begin n_bad++; $display("FAIL rnd_issue[%0d]: out_valid/stall got %b want %b", n, {bus.out_valid, bus.stall}, {e_out_valid, e_stall}); end
      n_cmp++; if (bus.wr_index !== 4'(e_wr_idx) || bus.rd_index !== 4'(e_rd_idx)) begin n_bad++; $display("FAIL rnd_idx[%0d]: wr=%0d rd=%0d want %0d/%0d", n, bus.wr_index, bus.rd_index, e_wr_idx, e_rd_idx); end
      tick();
    end
  endtask

  task automatic test_async_reset();
    do_flush();
    for (int k = 0; k < 6; k++) begin
      set_in(1'b1, i_type(k + 1, 0, k), 1'b1, 1'b1, (k > 2), 1'b0);
      tick();
    end
    set_in(1'b1, i_type(20, 0, 3), 1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    rst = 1'b0;
    #1;
    model_reset();
    n_cmp++; if ({bus.wr_index, bus.rd_index, bus.count} !== 13'd0) begin n_bad++; $display("FAIL areset_idx_count: got %h want 0", {bus.wr_index, bus.rd_index, bus.count}); end
    n_cmp++; if ({bus.empty, bus.full, bus.in_ready, bus.out_valid, bus.stall} !== 5'b10100) begin n_bad++; $display("FAIL areset_flags: empty/full/in_ready/out_valid/stall got %b want 10100", {bus.empty, bus.full, bus.in_ready, bus.out_valid, bus.stall}); end
    @(negedge clk);
    rst = 1'b1;
    set_in(1'b1, i_type(3, 0, 7), 1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (bus.wr_en !== 1'b1 || bus.wr_index !== 4'd0) begin n_bad++; $display("FAIL areset_first_enq: wr_en=%b wr_index=%0d want 1/0", bus.wr_en, bus.wr_index); end
    tick();
    set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (bus.count !== 5'd1 || bus.wr_index !== 4'd1 || bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL areset_after: count=%0d wr=%0d out_valid=%b want 1/1/1", bus.count, bus.wr_index, bus.out_valid); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    test_reset();
    test_fill();
    test_back_to_back();
    test_hazard();
    test_zero_reg();
    test_flush();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
